// File: rtl/sha256_message_padder_if.sv
// sha256_message_padder_if: word-in / padded-block-out handshake bundle.
interface sha256_message_padder_if;
  logic [31:0]  data_i;
  logic         v_i;
  logic         last_i;
  logic [1:0]   last_bytes_i;
  logic         ready_o;
  logic [511:0] block_o;
  logic         block_v_o;
  logic         block_last_o;
  logic         block_yumi_i;
  modport master (
    output data_i, v_i, last_i, last_bytes_i, block_yumi_i,
    input  ready_o, block_o, block_v_o, block_last_o
  );
  modport slave (
    input  data_i, v_i, last_i, last_bytes_i, block_yumi_i,
    output ready_o, block_o, block_v_o, block_last_o
  );
endinterface

// File: rtl/sha256_message_padder.sv
// sha256_message_padder: packs 32-bit message words into padded 512-bit SHA-256 blocks.
module sha256_message_padder (
  input  logic                    clk_i,
  input  logic                    reset_i,
  sha256_message_padder_if.slave  bus
);
  localparam logic [2:0] FILL = 3'd0, PAD = 3'd1, LEN = 3'd2, EMIT = 3'd3, EMIT_FINAL = 3'd4;
  logic [2:0]        state, after;
  logic [15:0][31:0] words;
  logic [3:0]        idx;
  logic [63:0]       len;
  logic              wrap;
  logic              take;
  logic [2:0]        k;
  logic [31:0]       word_in;
  assign take = bus.v_i && bus.ready_o;
  assign k = bus.last_bytes_i == 2'd0 ? 3'd4 : {1'b0, bus.last_bytes_i};
  // a short final word carries its own 0x80 marker so no separate PAD cycle is needed
  always_comb
    word_in = !bus.last_i ? bus.data_i :
              k == 3'd1   ? {bus.data_i[31:24], 24'h800000} :
              k == 3'd2   ? {bus.data_i[31:16], 16'h8000} :
              k == 3'd3   ? {bus.data_i[31:8], 8'h80} : bus.data_i;
  assign bus.ready_o      = state == FILL && !reset_i;
  assign bus.block_v_o    = state == EMIT || state == EMIT_FINAL;
  assign bus.block_last_o = state == EMIT_FINAL;
  assign bus.block_o      = words;
  // word 0 lives in the top slot, so slot idx maps to packed index ~idx
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state <= FILL;
      after <= FILL;
      words <= '0;
      idx   <= '0;
      len   <= '0;
      wrap  <= 1'b0;
    end else case (state)
      FILL: if (take) begin
        words[~idx] <= word_in;
        idx         <= idx + 4'd1;
        wrap        <= idx == 4'd15;
        len         <= len + (bus.last_i ? {58'd0, k, 3'd0} : 64'd32);
        if (!bus.last_i) begin
          if (idx == 4'd15) begin
            state <= EMIT;
            after <= FILL;
          end
        end else if (k == 3'd4) state <= PAD;
        else begin
          state <= idx <= 4'd13 ? LEN : EMIT;
          after <= LEN;
        end
      end
      PAD: if (wrap) begin
        state <= EMIT;
        after <= PAD;
      end else begin
        words[~idx] <= 32'h8000_0000;
        state       <= idx <= 4'd13 ? LEN : EMIT;
        after       <= LEN;
      end
      LEN: begin
        words[1] <= len[63:32];
        words[0] <= len[31:0];
        state    <= EMIT_FINAL;
      end
      EMIT: if (bus.block_yumi_i) begin
        words <= '0;
        idx   <= '0;
        wrap  <= 1'b0;
        state <= after;
      end
      EMIT_FINAL: if (bus.block_yumi_i) begin
        words <= '0;
        idx   <= '0;
        wrap  <= 1'b0;
        len   <= '0;
        state <= FILL;
      end
      default: state <= FILL;
    endcase
endmodule

// File: tb/tb_sha256_message_padder.sv
// tb_sha256_message_padder: directed scoreboard bench built on a byte-level padding model.
module tb_sha256_message_padder;
  typedef struct {
    logic [511:0] blk;
    logic         last;
  } exp_t;
  localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  exp_t q[$];
  logic [31:0] msg [32];
  logic [511:0] got_blk = '0;
  logic [511:0] held;
  always #5 clk = ~clk;
  sha256_message_padder_if bus ();
  sha256_message_padder dut (.clk_i(clk), .reset_i(rst), .bus(bus));
  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic chk_out();
    exp_t e;
    if (bus.block_v_o && bus.block_yumi_i) begin
      if (q.size() == 0) chk("unexpected_block", bus.block_o, 512'hx);
      else begin
        e = q.pop_front();
        got_blk = bus.block_o;
        chk("block", bus.block_o, e.blk);
        chk("block_last", {511'd0, bus.block_last_o}, {511'd0, e.last});
      end
    end
  endtask
  task automatic tick();
    @(negedge clk);
    chk_out();
    @(posedge clk);
    #1;
  endtask
  task automatic send_msg(input int n, input int k, input int stop_at);
    byte unsigned b[$];
    logic [63:0] bl;
    exp_t e;
    logic acc;
    int budget;
    if (stop_at == n) begin
      for (int i = 0; i < n; i++)
        for (int j = 0; j < ((i == n - 1) ? k : 4); j++) b.push_back(msg[i][31-8*j -: 8]);
      bl = 64'(b.size()) * 8;
      b.push_back(8'h80);
      while (b.size() % 64 != 56) b.push_back(8'h00);
      for (int j = 7; j >= 0; j--) b.push_back(bl[8*j +: 8]);
      for (int x = 0; x < b.size() / 64; x++) begin
        for (int j = 0; j < 64; j++) e.blk[511-8*j -: 8] = b[64*x+j];
        e.last = (x == b.size() / 64 - 1);
        q.push_back(e);
      end
    end
    for (int i = 0; i < stop_at; i++) begin
      bus.v_i = 1'b1;
      bus.data_i = msg[i];
      bus.last_i = (i == n - 1);
      bus.last_bytes_i = (k == 4) ? 2'd0 : 2'(k);
      budget = 50;
      do begin
        @(negedge clk);
        chk_out();
        acc = bus.ready_o;
        @(posedge clk);
        #1;
        budget--;
      end while (!acc && budget > 0);
      if (!acc) chk("accept_timeout", {511'd0, acc}, 512'd1);
    end
    bus.v_i = 1'b0;
    bus.last_i = 1'b0;
  endtask
  task automatic drain();
    int budget = 200;
    while (q.size() > 0 && budget > 0) begin
      tick();
      budget--;
    end
    chk("drain_pending", 512'(q.size()), 512'd0);
  endtask
  task automatic rand_msg();
    for (int i = 0; i < 32; i++) msg[i] = $urandom;
  endtask
  initial begin
    bus.v_i = 1'b0;
    bus.data_i = '0;
    bus.last_i = 1'b0;
    bus.last_bytes_i = '0;
    bus.block_yumi_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", {511'd0, bus.ready_o}, 512'd0);
    chk("reset_block_v", {511'd0, bus.block_v_o}, 512'd0);
    chk("reset_block", bus.block_o, 512'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    msg[0] = 32'h61626300;
    send_msg(1, 3, 1);
    drain();
    chk("abc_const", got_blk, ABC);
    rand_msg();
    send_msg(14, 4, 14);
    drain();
    rand_msg();
    send_msg(16, 4, 16);
    drain();
    rand_msg();
    send_msg(15, 2, 15);
    drain();
    rand_msg();
    send_msg(16, 1, 16);
    drain();
    rand_msg();
    send_msg(14, 3, 14);
    drain();
    bus.block_yumi_i = 1'b0;
    msg[0] = 32'h61626377;
    send_msg(1, 3, 1);
    for (int i = 0; i < 20 && !bus.block_v_o; i++) tick();
    held = bus.block_o;
    chk("hold_ready_block", held, ABC);
    rand_msg();
    bus.v_i = 1'b1;
    bus.data_i = msg[0];
    bus.last_i = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("hold_block", bus.block_o, held);
      chk("hold_block_v", {511'd0, bus.block_v_o}, 512'd1);
      chk("hold_ready", {511'd0, bus.ready_o}, 512'd0);
      @(posedge clk);
      #1;
    end
    bus.v_i = 1'b0;
    bus.block_yumi_i = 1'b1;
    drain();
    send_msg(3, 4, 3);
    drain();
    rand_msg();
    send_msg(10, 4, 7);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_ready", {511'd0, bus.ready_o}, 512'd0);
    chk("midreset_block_v", {511'd0, bus.block_v_o}, 512'd0);
    chk("midreset_block", bus.block_o, 512'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    msg[0] = 32'h61626300;
    send_msg(1, 3, 1);
    drain();
    chk("abc_after_reset", got_blk, ABC);
    rand_msg();
    send_msg(5, 4, 5);
    msg[0] = 32'hdeadbeef;
    msg[1] = 32'h01234567;
    msg[2] = 32'h89abcdef;
    send_msg(3, 2, 3);
    drain();
    chk("b2b_length", {480'd0, got_blk[31:0]}, 512'd80);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sha256_message_padder.md
SHA256_MESSAGE_PADDER -- requirements
Module: SHA256_message_padder

Interface
REQ-001 The block SHALL have no parameters; word width is 32, block width is 512, and the length field is 64 bits.
REQ-002 clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-003 reset_i  input  1  asynchronous, active-high reset.
REQ-004 data_i  input  32  message word, big-endian, first byte in [31:24].
REQ-005 v_i  input  1  data_i valid; a word is accepted on a cycle where v_i & ready_o.
REQ-006 last_i  input  1  the accepted word is the final word of the message.
REQ-007 last_bytes_i  input  2  valid bytes in the final word (0 means 4, 1..3 means that count); ignored unless last_i.
REQ-008 ready_o  output  1  padder can accept a word this cycle.
REQ-009 block_o  output  512  padded block; word 0 in [511:480], word 15 in [31:0], matching the scheduler's M_i layout.
REQ-010 block_v_o  output  1  block_o is valid.
REQ-011 block_last_o  output  1  block_o is the final block of the message; meaningful only while block_v_o.
REQ-012 block_yumi_i  input  1  consumer takes the block; legal only while block_v_o.

Function
REQ-013 The state machine SHALL have the states FILL, PAD, LEN, EMIT and EMIT_FINAL.
REQ-014 ready_o SHALL be 1 only in FILL with reset_i low; block_v_o SHALL be 1 only in EMIT or EMIT_FINAL; block_last_o SHALL be 1 only in EMIT_FINAL.
REQ-015 A 4-bit word index idx SHALL select the buffer slot, starting at 0; each accepted word writes slot idx and increments idx.
REQ-016 A 64-bit bit-length counter SHALL add 32 per accepted non-final word, or 8*k for the final word (k = 4 if last_bytes_i = 0, else last_bytes_i), wrapping mod 2^64.
REQ-017 In FILL, an accepted non-last word at idx 15 SHALL move the state to EMIT.
REQ-018 For a final word with k < 4, the word SHALL be stored with bytes below the valid bytes replaced by 0x80 followed by zeros (e.g. k=3: {data_i[31:8],8'h80}), so padding is complete.
REQ-019 For a final word with k = 4, the word SHALL be stored unmodified and the state SHALL go to PAD.
REQ-020 PAD SHALL last one cycle and write 0x80000000 into slot idx; if idx was 0 after a wrap (final word was in slot 15), the current full block SHALL be emitted first via EMIT, and PAD SHALL be re-entered on the fresh block.
REQ-021 Once padding is complete with next free slot f: if f <= 14, the state SHALL go to LEN; otherwise it SHALL go to EMIT, then LEN on a fresh zeroed block.
REQ-022 LEN SHALL last one cycle, write length[63:32] to slot 14 and length[31:0] to slot 15, then go to EMIT_FINAL.
REQ-023 On block_v_o & block_yumi_i, the buffer SHALL clear to zero and idx SHALL return to 0.
REQ-024 After EMIT the state SHALL return to FILL, or to PAD/LEN if padding or length is still pending; after EMIT_FINAL it SHALL return to FILL and the length counter SHALL clear.
REQ-025 Under backpressure, block_o, block_v_o and block_last_o SHALL hold stable until accepted; no word SHALL be accepted while a block is held.
REQ-026 Zero-length messages SHALL NOT be supported; v_i with last_i and no preceding words is a one-word message.
REQ-027 block_o SHALL be driven directly from the buffer register, with no combinational path from data_i.

Reset
REQ-028 While reset_i is high, the state SHALL be FILL, the buffer, idx and length SHALL be 0, ready_o SHALL be 0 and block_v_o SHALL be 0.
REQ-029 Reset asserted mid-message or mid-EMIT SHALL abort the message, with no partial block emitted.
REQ-030 The first word SHALL be accepted on the first clock edge after reset_i deasserts with v_i high.

Verification
REQ-031 "abc" as one word 0x61626300 with last_i and last_bytes_i=3 -> one block, word0=0x61626380, words1-14=0, word15=0x00000018, block_last_o=1.
REQ-032 14 full words, last on the 14th -> block A has word14=0x80000000 and word15=0 with block_last_o=0; block B is all zero except word15=0x000001C0, with block_last_o=1.
REQ-033 16 full words, last on the 16th -> block A carries the data with last=0; block B has word0=0x80000000 and word15=0x00000200, with last=1.
REQ-034 block_yumi_i held low 5 cycles while block_v_o -> block_o is unchanged, ready_o=0, and no words are lost.
REQ-035 Reset pulsed at word 7, then "abc" sent -> output identical to REQ-031.
REQ-036 Two back-to-back messages -> the second length field counts only the second message.
